// File: rtl/fpu_stim_checker.sv
// Pipelined stimulus/compare engine for an FPU under verification: issues one
// pseudo-random op per cycle and checks the DUV result OUT_WAIT cycles later.
module fpu_stim_checker #(
    parameter int          WIDTH    = 32,
    parameter int          OPW      = 2,
    parameter int          OUT_WAIT = 3,
    parameter int          CLK_IDLE = 2,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] SEED_A   = 32'hACE1_0001,
    parameter logic [31:0] SEED_B   = 32'h1234_5679
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tests,
    input  logic [WIDTH-1:0] ref_result,
    input  logic [WIDTH-1:0] dut_result,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   opcode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_idx,
    output logic [CNT_W-1:0] first_fail_idx
);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] ref_val;
        logic [CNT_W-1:0] idx;
    } exp_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0]      TAPS        = 32'h8020_0003;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [7:0]       SETTLE_INIT = (CLK_IDLE > 0) ? 8'(CLK_IDLE - 1) : 8'd0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [WIDTH-1:0] widen(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[i % 32];
        return r;
    endfunction

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_lat, issue_idx, idx_nx, last_idx;
    logic [7:0]       settle_cnt;
    logic [31:0]      lfsr_a, lfsr_b, a_nx, b_nx;
    logic             load_first, load_next, start_ok, last_cmp;
    exp_t             cur_exp, cmp_exp;

    assign last_idx = n_lat - 1'b1;
    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign idx_nx   = load_first ? '0 : issue_idx + 1'b1;
    assign a_nx     = lfsr_step(lfsr_a);
    assign b_nx     = lfsr_step(lfsr_b);
    assign cur_exp  = '{valid: (state == S_ISSUE), ref_val: ref_result, idx: issue_idx};
    assign last_cmp = cmp_exp.valid && (cmp_exp.idx == last_idx);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nx   = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_tests == '0) begin
                        state_nx = S_DONE;
                    end else if (CLK_IDLE == 0) begin
                        state_nx   = S_ISSUE;
                        load_first = 1'b1;
                    end else begin
                        state_nx = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nx   = S_ISSUE;
                    load_first = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issue_idx == last_idx) state_nx = S_DRAIN;
                else                       load_next = 1'b1;
            end
            S_DRAIN: state_nx = S_DRAIN;
            default: state_nx = S_IDLE;
        endcase
        // The final compare ends the run, even on the edge that leaves ISSUE.
        if (last_cmp) state_nx = S_DONE;
    end

    // Expected-result delay line; OUT_WAIT==1 compares against the live reference.
    if (OUT_WAIT == 1) begin : g_direct
        assign cmp_exp = cur_exp;
    end else begin : g_pipe
        exp_t pipe [OUT_WAIT-1];
        // NOTE: only the valid bits are reset; payload is don't-care while invalid.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < OUT_WAIT - 1; i++) pipe[i].valid <= 1'b0;
            end else begin
                pipe[0] <= cur_exp;
                for (int i = 1; i < OUT_WAIT - 1; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign cmp_exp = pipe[OUT_WAIT-2];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            n_lat          <= '0;
            issue_idx      <= '0;
            settle_cnt     <= '0;
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
            op_a           <= '0;
            op_b           <= '0;
            opcode         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            mismatch       <= 1'b0;
            mismatch_idx   <= '0;
            first_fail_idx <= '1;
        end else begin
            state    <= state_nx;
            mismatch <= 1'b0;

            if (state == S_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

            if (cmp_exp.valid) begin
                if (dut_result == cmp_exp.ref_val) begin
                    if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
                end else begin
                    if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
                    mismatch     <= 1'b1;
                    mismatch_idx <= cmp_exp.idx;
                    if (first_fail_idx == '1) first_fail_idx <= cmp_exp.idx;
                end
                if (last_cmp) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end

            if (start_ok) begin
                n_lat          <= num_tests;
                settle_cnt     <= SETTLE_INIT;
                pass_count     <= '0;
                fail_count     <= '0;
                first_fail_idx <= '1;
                done           <= (num_tests == '0);
                busy           <= (num_tests != '0);
                op_a           <= '0;
                op_b           <= '0;
                opcode         <= '0;
            end

            // Placed last so a zero-settle start presents op 0 on the start edge.
            if (load_first || load_next) begin
                lfsr_a    <= a_nx;
                lfsr_b    <= b_nx;
                op_a      <= widen(a_nx);
                op_b      <= widen(b_nx);
                opcode    <= OPW'(idx_nx);
                issue_idx <= idx_nx;
            end
        end
    end

endmodule
